// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the pipeline-side signals seen by the hazard/stall controller.
//   master : the pipeline datapath (drives ID/EX hazard sources, observes
//            the stall/flush controls).
//   slave  : hazard_ctrl itself.
//
//   ID-stage sources : id_rs, id_rt, id_uses_rs, id_uses_rt,
//                      id_mdu_start, id_reads_hilo
//   EX-stage sources : ex_memread, ex_rt, ex_branch_taken
//   Controls         : pc_write, ifid_write, ifid_flush, idex_bubble
//   Status           : mdu_busy, stall_cycles (16-bit, saturating)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_mdu_start;
  logic        id_reads_hilo;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mdu_busy;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_reads_hilo,
           ex_memread, ex_rt, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_reads_hilo,
           ex_memread, ex_rt, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall controller for the 5-stage pipeline.
//   - Load-use hazard between a load in EX and a consumer in ID: one-cycle
//     stall (PC and IF/ID held, bubble into ID/EX).
//   - Multiply/divide unit sequencing: an issued MDU op keeps the unit busy
//     for MDU_LAT cycles; mfhi/mflo or another MDU op in ID stalls meanwhile.
//   - Taken branch in EX: flush IF/ID and bubble ID/EX; overrides stalls and
//     suppresses an MDU issue from the (wrong-path) ID instruction.
//   - Saturating 16-bit count of cycles with pc_write low.
//
// Parameters
//   MDU_LAT : cycles an issued MDU op occupies HI/LO (1..63).
//
// Ports
//   clk   : pipeline clock, rising-edge
//   rst_n : asynchronous active-low reset
//   hz    : hazard_ctrl_if.slave (hazard sources in, controls/status out)
//
// Controls are combinational from the current inputs and the busy counter.
// While rst_n is low the pipeline is frozen with a bubble in ID/EX.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MDU_LAT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam logic [5:0] LAT_LOAD = 6'(MDU_LAT);

  // Busy counter: zero means idle, non-zero counts remaining busy cycles.
  logic [5:0]  cnt;
  logic [15:0] stall_cnt;

  logic        busy;
  logic        lu;
  logic        mh;
  logic        issue;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    busy = (cnt != 6'd0);

    // Register 0 is never a real producer, so a load "to" r0 cannot hazard.
    lu = hz.ex_memread && (hz.ex_rt != 5'd0) &&
         ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
          (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));

    // A second MDU op while busy stalls too, so ops never overlap.
    mh = busy && (hz.id_reads_hilo || hz.id_mdu_start);

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    issue       = 1'b0;

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // ID holds a wrong-path instruction: its hazards and MDU issue are moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu || mh) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      issue = hz.id_mdu_start;
    end
  end

  // An in-flight MDU op is never cancelled by a flush; only reset discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 6'd0;
    end else if (issue) begin
      cnt <= LAT_LOAD;
    end else if (busy) begin
      cnt <= cnt - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (!pc_write) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.mdu_busy     = busy;
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl with MDU_LAT = 4. Inputs change 1 time unit
//   after the rising edge; combinational controls are sampled mid-cycle.
//   ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_stall;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MDU_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] ctl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.mdu_busy};

  localparam logic [4:0] RUN      = 5'b11000;
  localparam logic [4:0] RUN_BSY  = 5'b11001;
  localparam logic [4:0] STALL    = 5'b00010;
  localparam logic [4:0] STALL_B  = 5'b00011;
  localparam logic [4:0] FLUSH    = 5'b11110;
  localparam logic [4:0] FLUSH_B  = 5'b11111;
  localparam logic [4:0] IN_RST   = 5'b00010;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  task automatic set_idle;
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.id_mdu_start = 1'b0; hz.id_reads_hilo = 1'b0;
    hz.ex_memread = 1'b0; hz.ex_rt = 5'd0; hz.ex_branch_taken = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hz.id_rs = 5'($urandom); hz.id_rt = 5'($urandom);
      hz.id_uses_rs = 1'($urandom); hz.id_uses_rt = 1'($urandom);
      hz.id_mdu_start = 1'($urandom); hz.id_reads_hilo = 1'($urandom);
      hz.ex_memread = 1'($urandom); hz.ex_rt = 5'($urandom);
      hz.ex_branch_taken = 1'($urandom);
      settle();
      n_cmp++; if (ctl !== IN_RST) begin n_err++; $display("FAIL reset_ctl[%0d]: got %b want %b", i, ctl, IN_RST); end
      n_cmp++; if (hz.stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_stall[%0d]: got %0d want 0", i, hz.stall_cycles); end
      next_cycle();
    end
    set_idle();
    rst_n = 1'b1;
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL reset_release_ctl: got %b want %b", ctl, RUN); end
    next_cycle();
    n_cmp++; if (hz.stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_release_stall: got %0d want 0", hz.stall_cycles); end
    exp_stall = 16'd0;
  endtask

  task automatic test_load_use;
    // rt match
    hz.ex_memread = 1'b1; hz.ex_rt = 5'd8; hz.id_uses_rt = 1'b1; hz.id_rt = 5'd8;
    settle();
    n_cmp++; if (ctl !== STALL) begin n_err++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, STALL); end
    next_cycle(); set_idle(); exp_stall = exp_stall + 16'd1;
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL lu_after_ctl: got %b want %b", ctl, RUN); end
    n_cmp++; if (hz.stall_cycles !== exp_stall) begin n_err++; $display("FAIL lu_rt_stall: got %0d want %0d", hz.stall_cycles, exp_stall); end
    next_cycle();
    // load to r0 never hazards
    hz.ex_memread = 1'b1; hz.ex_rt = 5'd0; hz.id_uses_rt = 1'b1; hz.id_rt = 5'd0;
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL lu_r0_ctl: got %b want %b", ctl, RUN); end
    next_cycle(); set_idle();
    // rs match
    hz.ex_memread = 1'b1; hz.ex_rt = 5'd5; hz.id_uses_rs = 1'b1; hz.id_rs = 5'd5; hz.id_rt = 5'd9;
    settle();
    n_cmp++; if (ctl !== STALL) begin n_err++; $display("FAIL lu_rs_ctl: got %b want %b", ctl, STALL); end
    next_cycle(); set_idle(); exp_stall = exp_stall + 16'd1;
    // rs field matches but the instruction does not read rs
    hz.ex_memread = 1'b1; hz.ex_rt = 5'd5; hz.id_uses_rs = 1'b0; hz.id_rs = 5'd5;
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL lu_unused_ctl: got %b want %b", ctl, RUN); end
    // non-load in EX
    hz.ex_memread = 1'b0; hz.id_uses_rs = 1'b1;
    #1;
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL lu_noload_ctl: got %b want %b", ctl, RUN); end
    next_cycle(); set_idle();
    settle();
    n_cmp++; if (hz.stall_cycles !== exp_stall) begin n_err++; $display("FAIL lu_total_stall: got %0d want %0d", hz.stall_cycles, exp_stall); end
    next_cycle();
  endtask

  task automatic test_mdu_seq;
    hz.id_mdu_start = 1'b1;
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL mdu_issue_ctl: got %b want %b", ctl, RUN); end
    next_cycle();
    hz.id_mdu_start = 1'b0; hz.id_reads_hilo = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      settle();
      n_cmp++; if (ctl !== STALL_B) begin n_err++; $display("FAIL mdu_busy_ctl[T+%0d]: got %b want %b", k, ctl, STALL_B); end
      next_cycle(); exp_stall = exp_stall + 16'd1;
    end
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL mdu_done_ctl: got %b want %b", ctl, RUN); end
    n_cmp++; if (hz.stall_cycles !== exp_stall) begin n_err++; $display("FAIL mdu_stall: got %0d want %0d", hz.stall_cycles, exp_stall); end
    next_cycle(); set_idle();
  endtask

  task automatic test_back_to_back;
    hz.id_mdu_start = 1'b1;
    next_cycle();
    for (int k = 1; k <= LAT; k++) begin
      settle();
      n_cmp++; if (ctl !== STALL_B) begin n_err++; $display("FAIL b2b_wait_ctl[T+%0d]: got %b want %b", k, ctl, STALL_B); end
      next_cycle(); exp_stall = exp_stall + 16'd1;
    end
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL b2b_issue2_ctl: got %b want %b", ctl, RUN); end
    next_cycle(); set_idle();
    for (int k = 1; k <= LAT; k++) begin
      settle();
      n_cmp++; if (ctl !== RUN_BSY) begin n_err++; $display("FAIL b2b_busy2_ctl[%0d]: got %b want %b", k, ctl, RUN_BSY); end
      next_cycle();
    end
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL b2b_idle_ctl: got %b want %b", ctl, RUN); end
    n_cmp++; if (hz.stall_cycles !== exp_stall) begin n_err++; $display("FAIL b2b_stall: got %0d want %0d", hz.stall_cycles, exp_stall); end
    next_cycle();
  endtask

  task automatic test_branch_priority;
    hz.ex_branch_taken = 1'b1;
    hz.ex_memread = 1'b1; hz.ex_rt = 5'd8; hz.id_uses_rt = 1'b1; hz.id_rt = 5'd8;
    hz.id_mdu_start = 1'b1;
    settle();
    n_cmp++; if (ctl !== FLUSH) begin n_err++; $display("FAIL br_prio_ctl: got %b want %b", ctl, FLUSH); end
    next_cycle(); set_idle();
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL br_no_issue_ctl: got %b want %b", ctl, RUN); end
    n_cmp++; if (hz.stall_cycles !== exp_stall) begin n_err++; $display("FAIL br_prio_stall: got %0d want %0d", hz.stall_cycles, exp_stall); end
    next_cycle();
  endtask

  task automatic test_branch_busy;
    hz.id_mdu_start = 1'b1;
    next_cycle(); set_idle();
    settle();
    n_cmp++; if (ctl !== RUN_BSY) begin n_err++; $display("FAIL brb_t1_ctl: got %b want %b", ctl, RUN_BSY); end
    next_cycle();
    // branch at T+2 together with an MDU hazard: flush wins, no stall
    hz.ex_branch_taken = 1'b1; hz.id_reads_hilo = 1'b1;
    settle();
    n_cmp++; if (ctl !== FLUSH_B) begin n_err++; $display("FAIL brb_t2_ctl: got %b want %b", ctl, FLUSH_B); end
    next_cycle(); set_idle();
    for (int k = 3; k <= LAT; k++) begin
      settle();
      n_cmp++; if (ctl !== RUN_BSY) begin n_err++; $display("FAIL brb_t%0d_ctl: got %b want %b", k, ctl, RUN_BSY); end
      next_cycle();
    end
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL brb_end_ctl: got %b want %b", ctl, RUN); end
    n_cmp++; if (hz.stall_cycles !== exp_stall) begin n_err++; $display("FAIL brb_stall: got %0d want %0d", hz.stall_cycles, exp_stall); end
    next_cycle();
  endtask

  task automatic test_reset_mid_op;
    hz.id_mdu_start = 1'b1;
    next_cycle(); set_idle();
    next_cycle();
    #2;
    n_cmp++; if (hz.mdu_busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre_busy: got %b want 1", hz.mdu_busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctl !== IN_RST) begin n_err++; $display("FAIL rmid_async_ctl: got %b want %b", ctl, IN_RST); end
    n_cmp++; if (hz.stall_cycles !== 16'd0) begin n_err++; $display("FAIL rmid_stall: got %0d want 0", hz.stall_cycles); end
    next_cycle(); next_cycle();
    rst_n = 1'b1; exp_stall = 16'd0;
    settle();
    n_cmp++; if (ctl !== RUN) begin n_err++; $display("FAIL rmid_release_ctl: got %b want %b", ctl, RUN); end
    next_cycle();
  endtask

  task automatic test_saturation;
    hz.ex_memread = 1'b1; hz.ex_rt = 5'd3; hz.id_uses_rs = 1'b1; hz.id_rs = 5'd3;
    repeat (65534) @(posedge clk);
    #1;
    n_cmp++; if (hz.stall_cycles !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe: got %h want fffe", hz.stall_cycles); end
    next_cycle();
    n_cmp++; if (hz.stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff: got %h want ffff", hz.stall_cycles); end
    repeat (70000 - 65535) @(posedge clk);
    #1;
    n_cmp++; if (hz.stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", hz.stall_cycles); end
    n_cmp++; if (ctl !== STALL) begin n_err++; $display("FAIL sat_ctl: got %b want %b", ctl, STALL); end
    set_idle();
    next_cycle();
    n_cmp++; if (hz.stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_idle_hold: got %h want ffff", hz.stall_cycles); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_stall = 16'd0;
    rst_n = 1'b0;
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_mdu_seq();
    test_back_to_back();
    test_branch_priority();
    test_branch_busy();
    test_reset_mid_op();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage processor. Detects load-use hazards between the EX and ID stages and sequences multi-cycle multiply/divide (MDU) operations with an internal busy counter. On a taken branch it flushes the wrong-path instructions. It drives the PC, IF/ID and ID/EX write/bubble controls, and keeps a saturating stall-cycle count for performance monitoring.

## Interface
- MDU_LAT, 32, cycles an issued MDU op occupies HI/LO; legal range 1..63.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  5  rs field of instruction in ID.
- id_rt  input  5  rt field of instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_mdu_start  input  1  ID instruction is mult/multu/div/divu.
- id_reads_hilo  input  1  ID instruction is mfhi/mflo.
- ex_memread  input  1  EX instruction is a load.
- ex_rt  input  5  destination register of EX load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  IF/ID register cleared to NOP.
- idex_bubble  output  1  ID/EX register loaded with NOP controls.
- mdu_busy  output  1  MDU op in flight.
- stall_cycles  output  16  count of cycles with pc_write=0, saturating.

## Operation
- State: a 6-bit counter `cnt` and the 16-bit `stall_cycles` count. mdu_busy = (cnt != 0). Busy is not a separate FSM state: IDLE ≡ cnt==0, BUSY ≡ cnt!=0.
- Load-use hazard `lu` is true when all of the following hold:
  - ex_memread=1 and ex_rt!=0;
  - (id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt).
- MDU hazard `mh` is true when mdu_busy=1 and (id_reads_hilo or id_mdu_start).
- Priority 1, ex_branch_taken=1:
  - ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1;
  - lu and mh are ignored because the ID instruction is wrong-path;
  - an id_mdu_start in the same cycle is NOT issued.
- Priority 2, lu or mh: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- Otherwise: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- MDU issue happens when id_mdu_start=1, no branch, and no lu/mh that cycle. At that edge, cnt loads MDU_LAT.
- Else, when cnt!=0, cnt decrements by 1 each cycle. An MDU op already in flight is never cancelled by a branch flush.
- stall_cycles increments on every edge where pc_write=0 and rst_n=1. It holds at 16'hFFFF.
- Reset, while rst_n=0 (asynchronous assert):
  - cnt=0, stall_cycles=0;
  - outputs forced to pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, mdu_busy=0;
  - cycles spent in reset do not count as stalls.
  - Reset mid-MDU discards the op; busy drops immediately.
- After reset release, outputs follow the rules above from the first cycle.

## Timing
- pc_write, ifid_write, ifid_flush and idex_bubble are combinational from inputs and cnt, valid in the same cycle. Upstream must hold ID inputs stable while stalled.
- Load-use stall lasts exactly 1 cycle: the next cycle the load has left EX and ex_memread drops.
- MDU issue in cycle T:
  - mdu_busy=1 in cycles T+1..T+MDU_LAT;
  - mdu_busy=0 from T+MDU_LAT+1.
- mfhi in ID at T+1 stalls through T+MDU_LAT and proceeds at T+MDU_LAT+1, i.e. MDU_LAT stall cycles.
- A second mult arriving while busy stalls likewise. It issues in the first non-busy cycle; there is no back-to-back overlap.
- Branch and hazard in the same cycle: the branch wins; no stall is counted.
- stall_cycles is updated at the clock edge closing the stalled cycle, so it is visible one cycle later.

## Test plan
- Reset:
  - stimulus: hold rst_n=0 for 3 cycles with random inputs;
  - required: pc_write=0, idex_bubble=1, mdu_busy=0, stall_cycles=0;
  - then deassert with idle inputs → pc_write=1, ifid_write=1, idex_bubble=0.
- Load-use:
  - stimulus: ex_memread=1, ex_rt=8, id_uses_rt=1, id_rt=8 for one cycle;
  - required: that cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1 next cycle;
  - repeat with ex_rt=0 → no stall.
- MDU sequence (MDU_LAT=4):
  - stimulus: id_mdu_start at T, then id_reads_hilo=1 from T+1;
  - required: mdu_busy high T+1..T+4, pc_write=0 T+1..T+4, pc_write=1 at T+5, stall_cycles=4.
- Branch priority:
  - stimulus: ex_branch_taken=1 with a simultaneous load-use match and id_mdu_start;
  - required: ifid_flush=1, idex_bubble=1, pc_write=1, no stall counted, cnt stays 0.
- Branch during busy:
  - stimulus: issue an MDU op, then ex_branch_taken at T+2;
  - required: flush asserted, mdu_busy stays high until T+MDU_LAT.
- Reset mid-operation and saturation:
  - stimulus: pulse rst_n low at T+2 of an MDU op;
  - required: mdu_busy=0 immediately, without waiting for a clock edge;
  - stimulus: force 70000 consecutive stall cycles → stall_cycles=16'hFFFF and held there.
